// File: rtl/bram_dp_true_be.sv
// True dual-port byte-write RAM on one clock, selectable same-port read-during-write mode.
// Latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); no backpressure, every enabled access is taken.
module bram_dp_true_be #(
   parameter int    RAM_WIDTH     = 32,
   parameter int    RAM_ADDR_BITS = 4,
   parameter int    BYTE_WIDTH    = 8,
   parameter string WRITE_MODE    = "READ_FIRST",
   parameter int    OUT_REG       = 0,
   localparam int   NB            = RAM_WIDTH / BYTE_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     en_a_i,
   input  logic [NB-1:0]            we_a_i,
   input  logic [RAM_ADDR_BITS-1:0] addr_a_i,
   input  logic [RAM_WIDTH-1:0]     data_a_i,
   output logic [RAM_WIDTH-1:0]     data_a_o,
   output logic                     valid_a_o,
   input  logic                     en_b_i,
   input  logic [NB-1:0]            we_b_i,
   input  logic [RAM_ADDR_BITS-1:0] addr_b_i,
   input  logic [RAM_WIDTH-1:0]     data_b_i,
   output logic [RAM_WIDTH-1:0]     data_b_o,
   output logic                     valid_b_o,
   output logic                     collision_o
);

   localparam int RAM_DEPTH = 2 ** RAM_ADDR_BITS;
   localparam bit MODE_WF   = (WRITE_MODE == "WRITE_FIRST");
   localparam bit MODE_NC   = (WRITE_MODE == "NO_CHANGE");

   generate
      if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
         $error("bram_dp_true_be: RAM_WIDTH must be a multiple of BYTE_WIDTH");
      end
      if (WRITE_MODE != "READ_FIRST" && WRITE_MODE != "WRITE_FIRST" &&
          WRITE_MODE != "NO_CHANGE") begin : g_bad_mode
         $error("bram_dp_true_be: illegal WRITE_MODE");
      end
   endgenerate

   logic [RAM_WIDTH-1:0] old_a, old_b;
   logic [RAM_WIDTH-1:0] mask_a, mask_b;
   logic [RAM_WIDTH-1:0] merged_a, merged_b;

   // One narrow array per lane; B is written first so A wins on a shared lane.
   genvar k;
   generate
      for (k = 0; k < NB; k++) begin : g_lane
         logic [BYTE_WIDTH-1:0] mem [RAM_DEPTH];

         always_ff @(posedge clk_i) begin
            if (rst_n_i) begin
               if (en_b_i && we_b_i[k])
                  mem[addr_b_i] <= data_b_i[k*BYTE_WIDTH +: BYTE_WIDTH];
               if (en_a_i && we_a_i[k])
                  mem[addr_a_i] <= data_a_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end

         assign old_a[k*BYTE_WIDTH +: BYTE_WIDTH]  = mem[addr_a_i];
         assign old_b[k*BYTE_WIDTH +: BYTE_WIDTH]  = mem[addr_b_i];
         assign mask_a[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{we_a_i[k]}};
         assign mask_b[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{we_b_i[k]}};
      end
   endgenerate

   assign merged_a = (old_a & ~mask_a) | (data_a_i & mask_a);
   assign merged_b = (old_b & ~mask_b) | (data_b_i & mask_b);

   logic                 ld_a, ld_b;
   logic [RAM_WIDTH-1:0] nxt_a, nxt_b;
   logic                 col_hit;

   // Reads and READ_FIRST writes return the pre-edge word; NO_CHANGE writes load nothing.
   always_comb begin
      ld_a  = 1'b0;
      nxt_a = old_a;
      if (en_a_i) begin
         if (we_a_i == '0 || !(MODE_WF || MODE_NC)) begin
            ld_a = 1'b1;
         end else if (MODE_WF) begin
            ld_a  = 1'b1;
            nxt_a = merged_a;
         end
      end
   end

   always_comb begin
      ld_b  = 1'b0;
      nxt_b = old_b;
      if (en_b_i) begin
         if (we_b_i == '0 || !(MODE_WF || MODE_NC)) begin
            ld_b = 1'b1;
         end else if (MODE_WF) begin
            ld_b  = 1'b1;
            nxt_b = merged_b;
         end
      end
   end

   assign col_hit = en_a_i && en_b_i && (addr_a_i == addr_b_i) &&
                    ((we_a_i & we_b_i) != '0);

   logic [RAM_WIDTH-1:0] d_a_q, d_b_q;
   logic                 v_a_q, v_b_q, col_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         d_a_q <= '0;
         d_b_q <= '0;
         v_a_q <= 1'b0;
         v_b_q <= 1'b0;
         col_q <= 1'b0;
      end else begin
         v_a_q <= ld_a;
         v_b_q <= ld_b;
         col_q <= col_hit;
         if (ld_a) d_a_q <= nxt_a;
         if (ld_b) d_b_q <= nxt_b;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [RAM_WIDTH-1:0] d_a_q2, d_b_q2;
         logic                 v_a_q2, v_b_q2, col_q2;

         // Stage 1 already holds across idle cycles, so a plain copy keeps the hold behaviour.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               d_a_q2 <= '0;
               d_b_q2 <= '0;
               v_a_q2 <= 1'b0;
               v_b_q2 <= 1'b0;
               col_q2 <= 1'b0;
            end else begin
               d_a_q2 <= d_a_q;
               d_b_q2 <= d_b_q;
               v_a_q2 <= v_a_q;
               v_b_q2 <= v_b_q;
               col_q2 <= col_q;
            end
         end

         assign data_a_o    = d_a_q2;
         assign data_b_o    = d_b_q2;
         assign valid_a_o   = v_a_q2;
         assign valid_b_o   = v_b_q2;
         assign collision_o = col_q2;
      end else begin : g_out_direct
         assign data_a_o    = d_a_q;
         assign data_b_o    = d_b_q;
         assign valid_a_o   = v_a_q;
         assign valid_b_o   = v_b_q;
         assign collision_o = col_q;
      end
   endgenerate

endmodule
